// File: rtl/data_memory_pipe_if.sv
// data_memory_pipe_if: M-stage load/store bus between the core and data memory.
// The core drives requests; the memory returns hit, busy and registered load data.
interface data_memory_pipe_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_req;
  logic        rd_req;
  logic [1:0]  size;
  logic        load_signed;
  logic        exception;
  logic [31:0] pc;
  logic        hit;
  logic        busy;
  logic        mem_wr;
  logic [31:0] rdata;
  logic        rvalid;
  logic        addr_err;

  modport master (
    output addr, wdata, wr_req, rd_req, size,
    output load_signed, exception, pc,
    input  hit, busy, mem_wr, rdata, rvalid, addr_err
  );

  modport slave (
    input  addr, wdata, wr_req, rd_req, size,
    input  load_signed, exception, pc,
    output hit, busy, mem_wr, rdata, rvalid, addr_err
  );
endinterface

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: byte-addressed 32-bit MEM-stage data memory with
// registered extended loads, misalign detection and a post-reset clear engine.
module data_memory_pipe #(
  parameter int          ADDR_W = 12,
  parameter int          DEPTH  = 3072,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  data_memory_pipe_if.slave bus
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr;
  logic [31:0] mem [2**ADDR_W];

  logic [31:0] off;
  logic [ADDR_W-1:0] widx;
  logic hit, mis, busy, ld_ok, we;
  logic [31:0] cur, merged, ld_val;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] rdata_q;
  logic rvalid_q, err_q;
  logic unused_bits;

  assign off  = bus.addr - BASE;
  assign widx = off[ADDR_W+1:2];
  assign cur  = mem[widx];
  assign busy = (state_q == CLEAR);

  assign hit = ({1'b0, bus.addr} >= {1'b0, BASE}) &&
               ({1'b0, bus.addr} < LIMIT);

  assign mis = (bus.size == 2'b11 && bus.addr[1:0] != 2'b00) ||
               (bus.size == 2'b01 && bus.addr[0]);

  assign we = bus.wr_req & hit & ~mis & ~bus.exception &
              ~busy & (bus.size != 2'b00);
  assign ld_ok = bus.rd_req & hit & ~mis & ~busy &
                 (bus.size != 2'b00);

  assign unused_bits = ^{bus.pc, off[31:ADDR_W+2], off[1:0]};

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && clr_ptr == LAST)
      state_d = IDLE;
  end

  always_comb begin
    merged = cur;
    unique case (bus.size)
      2'b11: merged = bus.wdata;
      2'b01: merged[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
      2'b10: merged[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
      default: merged = cur;
    endcase
  end

  assign ld_b = cur[{bus.addr[1:0], 3'b000} +: 8];
  assign ld_h = cur[{bus.addr[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = cur;
    unique case (bus.size)
      2'b10: ld_val = {{24{bus.load_signed & ld_b[7]}}, ld_b};
      2'b01: ld_val = {{16{bus.load_signed & ld_h[15]}}, ld_h};
      default: ld_val = cur;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= CLEAR;
      clr_ptr  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (busy)
        clr_ptr <= clr_ptr + 1'b1;
      rvalid_q <= ld_ok;
      if (ld_ok)
        rdata_q <= ld_val;
      err_q <= (bus.wr_req | bus.rd_req) & hit & mis & ~busy;
    end
  end

  // Non-blocking write keeps same-cycle loads read-first.
  always_ff @(posedge clk) begin
    if (busy && reset)
      mem[clr_ptr] <= '0;
    else if (we)
      mem[widx] <= merged;
  end

  assign bus.hit      = hit;
  assign bus.busy     = busy;
  assign bus.mem_wr   = we;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.addr_err = err_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: behavioural word-array model checked every cycle,
// plus directed loads/stores with literal expectations.
module tb_data_memory_pipe;
  localparam int DEPTH = 3072;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [1:0] SZ_W = 2'b11;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_B = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_memory_pipe_if bus();

  data_memory_pipe #(
    .ADDR_W(12),
    .DEPTH(DEPTH),
    .BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] mm [DEPTH];
  int  clr_left = -1;
  bit  live = 1'b0;
  logic [31:0] e_rdata = '0;
  bit  e_rvalid = 1'b0;
  bit  e_err = 1'b0;

  function automatic bit m_hit(logic [31:0] a);
    return ({32'b0, a} >= {32'b0, BASE}) &&
           ({32'b0, a} < {32'b0, BASE} + 64'(4 * DEPTH));
  endfunction

  function automatic bit m_mis(logic [1:0] sz, logic [31:0] a);
    if (sz == SZ_W) return a[1:0] != 2'b00;
    if (sz == SZ_H) return a[0];
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, logic [31:0] a,
                                         logic [1:0] sz, bit sgn);
    logic [31:0] v;
    int sh;
    v = w;
    if (sz == SZ_B) begin
      sh = 8 * int'(a[1:0]);
      v = (w >> sh) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == SZ_H) begin
      sh = a[1] ? 16 : 0;
      v = (w >> sh) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(logic [31:0] w, logic [31:0] a,
                                          logic [1:0] sz, logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (sz == SZ_W) return d;
    if (sz == SZ_H) begin
      sh = a[1] ? 16 : 0;
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((d & 32'hFFFF) << sh);
    end
    sh = 8 * int'(a[1:0]);
    mask = 32'hFF << sh;
    return (w & ~mask) | ((d & 32'hFF) << sh);
  endfunction

  function automatic bit m_store();
    return bus.wr_req && m_hit(bus.addr) && !m_mis(bus.size, bus.addr) &&
           !bus.exception && !(clr_left > 0) && bus.size != 2'b00;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      live = 1'b1;
      clr_left = DEPTH;
      e_rdata = '0;
      e_rvalid = 1'b0;
      e_err = 1'b0;
      foreach (mm[i]) mm[i] = '0;
    end else if (live) begin
      bit b, h, ms;
      int idx;
      b  = clr_left > 0;
      h  = m_hit(bus.addr);
      ms = m_mis(bus.size, bus.addr);
      idx = int'((bus.addr - BASE) >> 2);
      e_err = (bus.wr_req || bus.rd_req) && h && ms && !b;
      e_rvalid = bus.rd_req && h && !ms && !b && bus.size != 2'b00;
      if (e_rvalid)
        e_rdata = m_load(mm[idx], bus.addr, bus.size, bus.load_signed);
      if (m_store()) begin
        logic [31:0] mg;
        mg = m_merge(mm[idx], bus.addr, bus.size, bus.wdata);
        $display("%d@%h: *%h <= %h", $time, bus.pc,
                 bus.addr & 32'hFFFF_FFFC, mg);
        mm[idx] = mg;
      end
      if (b) clr_left--;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      #2;
      chk("busy", 32'(bus.busy), 32'(clr_left > 0));
      chk("hit", 32'(bus.hit), 32'(m_hit(bus.addr)));
      chk("mem_wr", 32'(bus.mem_wr), 32'(m_store()));
      chk("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
      chk("addr_err", 32'(bus.addr_err), 32'(e_err));
      chk("rdata", bus.rdata, e_rdata);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic issue(bit wr, bit rd, logic [1:0] sz, bit sgn, bit exc,
                       logic [31:0] a, logic [31:0] d);
    bus.wr_req = wr;
    bus.rd_req = rd;
    bus.size = sz;
    bus.load_signed = sgn;
    bus.exception = exc;
    bus.addr = a;
    bus.wdata = d;
    bus.pc = pc_ctr;
    pc_ctr = pc_ctr + 4;
  endtask

  task automatic fin();
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.size = 2'b00;
    bus.exception = 1'b0;
    #1;
  endtask

  task automatic store(logic [1:0] sz, logic [31:0] a, logic [31:0] d);
    issue(1'b1, 1'b0, sz, 1'b0, 1'b0, a, d);
    fin();
  endtask

  task automatic load(string name, logic [1:0] sz, bit sgn,
                      logic [31:0] a, logic [31:0] exp);
    issue(1'b0, 1'b1, sz, sgn, 1'b0, a, 32'h0);
    fin();
    chk({name, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk(name, bus.rdata, exp);
  endtask

  task automatic count_clear(string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    issue(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("busy_in_reset", 32'(bus.busy), 32'd1);
    chk("rvalid_in_reset", 32'(bus.rvalid), 32'd0);
    chk("rdata_in_reset", bus.rdata, 32'h0);
    reset = 1'b1;
    count_clear("clear_cycles");
    @(negedge clk);
    #1;

    load("lw_word5", SZ_W, 1'b0, 32'h14, 32'h0);
    store(SZ_W, 32'h10, 32'h1234_5678);
    load("lw_0x10", SZ_W, 1'b0, 32'h10, 32'h1234_5678);
    store(SZ_B, 32'h12, 32'h0000_00AB);
    load("lw_after_sb", SZ_W, 1'b0, 32'h10, 32'h12AB_5678);

    store(SZ_W, 32'h20, 32'h8000_FF80);
    load("lb_0x20", SZ_B, 1'b1, 32'h20, 32'hFFFF_FF80);
    load("lbu_0x20", SZ_B, 1'b0, 32'h20, 32'h0000_0080);
    load("lh_0x22", SZ_H, 1'b1, 32'h22, 32'hFFFF_8000);
    load("lhu_0x22", SZ_H, 1'b0, 32'h22, 32'h0000_8000);
    load("lbu_0x23", SZ_B, 1'b0, 32'h23, 32'h0000_0080);

    issue(1'b1, 1'b0, SZ_W, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF);
    #1;
    chk("exc_mem_wr", 32'(bus.mem_wr), 32'd0);
    fin();
    load("lw_after_exc", SZ_W, 1'b0, 32'h10, 32'h12AB_5678);

    issue(1'b1, 1'b0, SZ_H, 1'b0, 1'b0, 32'h31, 32'h0000_BEEF);
    #1;
    chk("mis_mem_wr", 32'(bus.mem_wr), 32'd0);
    fin();
    chk("mis_addr_err", 32'(bus.addr_err), 32'd1);
    @(negedge clk);
    #1;
    chk("mis_err_pulse", 32'(bus.addr_err), 32'd0);
    load("lw_0x30", SZ_W, 1'b0, 32'h30, 32'h0);

    issue(1'b0, 1'b1, SZ_W, 1'b0, 1'b0, 32'h3000, 32'h0);
    #1;
    chk("oow_hit", 32'(bus.hit), 32'd0);
    fin();
    chk("oow_rvalid", 32'(bus.rvalid), 32'd0);

    issue(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h10, 32'h0);
    fin();
    chk("size0_rvalid", 32'(bus.rvalid), 32'd0);

    store(SZ_W, 32'h40, 32'h1111_1111);
    issue(1'b1, 1'b1, SZ_W, 1'b0, 1'b0, 32'h40, 32'hDEAD_BEEF);
    fin();
    chk("rd_first", bus.rdata, 32'h1111_1111);
    load("lw_after_rmw", SZ_W, 1'b0, 32'h40, 32'hDEAD_BEEF);

    // Restarted clear with requests held throughout.
    issue(1'b1, 1'b1, SZ_W, 1'b0, 1'b0, 32'h50, 32'hFFFF_FFFF);
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("busy_at_100", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    count_clear("restart_clear_cycles");
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.size = 2'b00;
    #1;
    load("lw_0x50_after_busy", SZ_W, 1'b0, 32'h50, 32'h0);
    load("lw_0x40_cleared", SZ_W, 1'b0, 32'h40, 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, 1'b1, SZ_W, 1'b0, 1'b0, BASE + 32'(4 * i), 32'h0);
      fin();
    end
    load("lw_last_word", SZ_W, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0);

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
- Parametrised, byte-addressed 32-bit data memory for the MEM stage of the pipelined MIPS core; next generation of the single-cycle DM.
- Adds parametrised depth and decode window, synchronous registered reads with lb/lbu/lh/lhu/lw extension, misalignment detection, exception-killed stores, and a sequential clear engine after reset.

Parameters:
- ADDR_W, 12, word-address width; array holds 2**ADDR_W words.
- DEPTH, 3072, number of implemented words, DEPTH <= 2**ADDR_W.
- BASE, 32'h0000_0000, byte base address of the window, word-aligned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  32  byte address (ALU result, M stage).
- wdata  in  32  store data, right-justified.
- wr_req  in  1  store request.
- rd_req  in  1  load request.
- size  in  2  2'b11 word, 2'b01 half, 2'b10 byte, 2'b00 no access.
- load_signed  in  1  1 = lb/lh sign-extend, 0 = zero-extend.
- exception  in  1  kills the current store.
- pc  in  32  instruction PC, for the store log only.
- hit  out  1  combinational: BASE <= addr < BASE + 4*DEPTH.
- busy  out  1  clear engine active.
- mem_wr  out  1  combinational effective store enable.
- rdata  out  32  registered, extended load data.
- rvalid  out  1  registered load-valid pulse.
- addr_err  out  1  registered misalignment flag.

Behaviour:
- Word index: widx = (addr - BASE) >> 2, truncated to ADDR_W bits.
- Reset, checked at every posedge while reset == 0:
  - state <= CLEAR, clr_ptr <= 0.
  - rdata <= 0, rvalid <= 0, addr_err <= 0.
  - busy reads 1 from the first edge with reset low.
- FSM state CLEAR:
  - Each cycle array[clr_ptr] <= 0, then clr_ptr++.
  - When clr_ptr == DEPTH-1, that word is written and state -> IDLE on the same edge.
  - Clear takes exactly DEPTH cycles after reset deasserts.
  - busy = 1 throughout. All requests are ignored: mem_wr = 0, rvalid = 0, addr_err = 0.
  - Reset reasserted mid-clear restarts the engine from 0.
- FSM state IDLE: busy = 0; stays IDLE until reset.
- Misalignment:
  - mis = (size==2'b11 && addr[1:0]!=0) || (size==2'b01 && addr[0]).
  - Byte accesses are never misaligned.
  - addr_err <= (wr_req | rd_req) & hit & mis & ~busy; a one-cycle pulse per request.
- Store:
  - mem_wr = wr_req & hit & ~mis & ~exception & ~busy & (size != 0).
  - Word: whole word written.
  - Half: addr[1]=1 writes bits [31:16], addr[1]=0 writes [15:0], both from wdata[15:0].
  - Byte: lane addr[1:0] (0 = [7:0] … 3 = [31:24]) written from wdata[7:0].
  - Unselected lanes are unchanged.
  - Simulation only: on each effective store, $display("%d@%h: *%h <= %h", $time, pc, word-aligned addr, merged word).
- Load:
  - Accepted when rd_req & hit & ~mis & ~busy & (size != 0).
  - Data is registered, 1-cycle latency: rvalid = 1 and rdata valid on the edge after acceptance.
  - Byte: lane selected by the latched addr[1:0], then sign- or zero-extended.
  - Half: lane selected by the latched addr[1], then extended.
  - Word: passed through unchanged.
  - Not accepted: rvalid <= 0 and rdata holds its previous value.
- Simultaneous rd_req and wr_req to the same word in one cycle: read-first, so the load returns the pre-store word.
- Out-of-window (hit = 0): no write, no rvalid, no addr_err. Another device owns that address.
- exception does not suppress loads; the pipeline discards them.

Test Plan:
- Reset low 2 cycles, then high → busy = 1 for exactly 3072 cycles, then 0. Read of word 5 returns 0. Pulse reset low at cycle 100 of the clear → the count restarts at 0.
- sw 0x12345678 @0x10, then lw @0x10 → next cycle rvalid = 1, rdata = 0x12345678. sb 0xAB @0x12 → the word reads 0x12AB5678.
- Word 0x8000FF80 @0x20: lb @0x20 → 0xFFFFFF80; lbu @0x20 → 0x00000080; lh @0x22 → 0xFFFF8000; lhu @0x22 → 0x00008000.
- sw with exception = 1 → mem_wr = 0, memory unchanged. sh @0x31 → addr_err pulses 1 cycle, no write. lw @0x3000 → hit = 0, rvalid = 0.
- Same-cycle sw 0xDEADBEEF and lw @0x40, whose word held 0x11111111 → rdata = 0x11111111; the following lw returns 0xDEADBEEF.
- Any request while busy = 1 → no write, rvalid = 0, addr_err = 0; the memory contents after the clear are all zero.
